// File: rtl/br_btb.sv
// br_btb: direct-mapped branch target buffer with 2-bit saturating direction
// counters. Lookup is combinational from the fetch PC; training arrives from
// the EX-stage branch resolution one instruction per cycle. Two free-running
// event counters track resolved control flow and mispredictions.
module br_btb #(
    parameter  int ENTRIES = 16,
    localparam int INDEX_W = $clog2(ENTRIES)
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_pc_if,
    output logic        o_hit,
    output logic        o_pred_taken,
    output logic [31:0] o_next_pc,
    input  logic        i_upd_valid,
    input  logic [31:0] i_upd_pc,
    input  logic        i_upd_is_jump,
    input  logic        i_upd_taken,
    input  logic [31:0] i_upd_target,
    input  logic        i_mispred,
    input  logic        i_tbl_clear,
    output logic [31:0] o_ctrl_cnt,
    output logic [31:0] o_mispred_cnt
);

    localparam int TAG_W = 32 - INDEX_W - 2;

    logic [ENTRIES-1:0] valid_q,   valid_d;
    logic [ENTRIES-1:0] is_jump_q, is_jump_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];
    logic [31:0]        ctrl_cnt_q,    ctrl_cnt_d;
    logic [31:0]        mispred_cnt_q, mispred_cnt_d;

    logic [INDEX_W-1:0] lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic [INDEX_W-1:0] upd_idx;
    logic [TAG_W-1:0]   upd_tag;
    logic               upd_hit;
    logic               taken_eff;
    logic               unused_pc_bits;

    // The two low PC bits never select an entry; only fetch uses them (pc+4).
    assign unused_pc_bits = ^i_upd_pc[1:0];

    assign lk_idx    = i_pc_if[INDEX_W+1:2];
    assign lk_tag    = i_pc_if[31:INDEX_W+2];
    assign upd_idx   = i_upd_pc[INDEX_W+1:2];
    assign upd_tag   = i_upd_pc[31:INDEX_W+2];
    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign taken_eff = i_upd_is_jump | i_upd_taken;

    // Lookup reads registered contents only, so a same-cycle update is not bypassed.
    always_comb begin
        o_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        o_pred_taken = o_hit && (is_jump_q[lk_idx] || ctr_q[lk_idx][1]);
        o_next_pc    = o_pred_taken ? target_q[lk_idx] : (i_pc_if + 32'd4);
    end

    // Training: a clear beats any update; hits retrain, taken misses allocate.
    always_comb begin
        valid_d   = valid_q;
        is_jump_d = is_jump_q;
        tag_d     = tag_q;
        target_d  = target_q;
        ctr_d     = ctr_q;
        if (i_tbl_clear) begin
            valid_d = '0;
        end else if (i_upd_valid) begin
            if (upd_hit) begin
                if (i_upd_is_jump) begin
                    target_d[upd_idx]  = i_upd_target;
                    ctr_d[upd_idx]     = 2'b11;
                    is_jump_d[upd_idx] = 1'b1;
                end else if (i_upd_taken) begin
                    target_d[upd_idx] = i_upd_target;
                    if (ctr_q[upd_idx] != 2'b11) begin
                        ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
                    end
                end else if (ctr_q[upd_idx] != 2'b00) begin
                    ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
                end
            end else if (taken_eff) begin
                valid_d[upd_idx]   = 1'b1;
                tag_d[upd_idx]     = upd_tag;
                target_d[upd_idx]  = i_upd_target;
                is_jump_d[upd_idx] = i_upd_is_jump;
                ctr_d[upd_idx]     = i_upd_is_jump ? 2'b11 : 2'b10;
            end
        end
    end

    // Event counters count every resolved instruction, even in a clear cycle.
    always_comb begin
        ctrl_cnt_d    = ctrl_cnt_q + {31'd0, i_upd_valid};
        mispred_cnt_d = mispred_cnt_q + {31'd0, i_upd_valid & i_mispred};
    end

    assign o_ctrl_cnt    = ctrl_cnt_q;
    assign o_mispred_cnt = mispred_cnt_q;

    // State registers; reset empties the table and seeds counters to weak-NT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q       <= '0;
            is_jump_q     <= '0;
            ctrl_cnt_q    <= '0;
            mispred_cnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else begin
            valid_q       <= valid_d;
            is_jump_q     <= is_jump_d;
            ctrl_cnt_q    <= ctrl_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
                ctr_q[i]    <= ctr_d[i];
            end
        end
    end

endmodule

// File: tb/tb_br_btb.sv
// tb_br_btb: directed and randomized checking of br_btb against a
// behavioural table model that works on whole PCs with plain arithmetic.
module tb_br_btb;

    localparam int ENTRIES = 16;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_if;
    logic        hit;
    logic        pred_taken;
    logic [31:0] next_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_jump;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        mispred;
    logic        tbl_clear;
    logic [31:0] ctrl_cnt;
    logic [31:0] mispred_cnt;

    int n_checks;
    int n_passed;

    // Reference model state, indexed by (pc / 4) mod ENTRIES.
    bit          m_valid  [ENTRIES];
    bit   [31:0] m_tag    [ENTRIES];
    bit   [31:0] m_target [ENTRIES];
    bit          m_jump   [ENTRIES];
    int          m_ctr    [ENTRIES];
    bit   [31:0] m_ctrl;
    bit   [31:0] m_misp;

    br_btb #(.ENTRIES(ENTRIES)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_pc_if       (pc_if),
        .o_hit         (hit),
        .o_pred_taken  (pred_taken),
        .o_next_pc     (next_pc),
        .i_upd_valid   (upd_valid),
        .i_upd_pc      (upd_pc),
        .i_upd_is_jump (upd_is_jump),
        .i_upd_taken   (upd_taken),
        .i_upd_target  (upd_target),
        .i_mispred     (mispred),
        .i_tbl_clear   (tbl_clear),
        .o_ctrl_cnt    (ctrl_cnt),
        .o_mispred_cnt (mispred_cnt)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Model reset: empty table, zero counters.
    function automatic void modelReset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]  = 0;
            m_tag[i]    = 0;
            m_target[i] = 0;
            m_jump[i]   = 0;
            m_ctr[i]    = 1;
        end
        m_ctrl = 0;
        m_misp = 0;
    endfunction

    // Model lookup from the current table contents.
    function automatic void modelLookup(input bit [31:0] pc, output bit h, output bit t, output bit [31:0] npc);
        int idx;
        bit [31:0] tg;
        idx = int'((pc / 4) % ENTRIES);
        tg  = pc / (4 * ENTRIES);
        h   = m_valid[idx] && (m_tag[idx] == tg);
        t   = h && (m_jump[idx] || (m_ctr[idx] >= 2));
        npc = t ? m_target[idx] : pc + 32'd4;
    endfunction

    // Model of one clock edge of training and counting.
    function automatic void modelUpdate(input bit uv, input bit [31:0] pc, input bit uj, input bit ut,
                                        input bit [31:0] tgt, input bit mp, input bit cl);
        int idx;
        bit [31:0] tg;
        bit teff;
        if (uv) m_ctrl = m_ctrl + 1;
        if (uv && mp) m_misp = m_misp + 1;
        if (cl) begin
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
        end else if (uv) begin
            idx  = int'((pc / 4) % ENTRIES);
            tg   = pc / (4 * ENTRIES);
            teff = uj || ut;
            if (m_valid[idx] && m_tag[idx] == tg) begin
                if (uj) begin
                    m_target[idx] = tgt;
                    m_ctr[idx]    = 3;
                    m_jump[idx]   = 1;
                end else if (ut) begin
                    m_target[idx] = tgt;
                    if (m_ctr[idx] < 3) m_ctr[idx] = m_ctr[idx] + 1;
                end else if (m_ctr[idx] > 0) begin
                    m_ctr[idx] = m_ctr[idx] - 1;
                end
            end else if (teff) begin
                m_valid[idx]  = 1;
                m_tag[idx]    = tg;
                m_target[idx] = tgt;
                m_jump[idx]   = uj;
                m_ctr[idx]    = uj ? 3 : 2;
            end
        end
    endfunction

    // Compare the three lookup outputs for the PC currently on pc_if.
    task automatic checkLookup(input string where);
        bit h, t;
        bit [31:0] npc;
        modelLookup(pc_if, h, t, npc);
        checkOutput({where, "_hit"},     {31'd0, hit},        {31'd0, h});
        checkOutput({where, "_taken"},   {31'd0, pred_taken}, {31'd0, t});
        checkOutput({where, "_next_pc"}, next_pc,             npc);
    endtask

    // One cycle: drive lookup and update, check the pre-edge lookup, then counters after the edge.
    task automatic applyStimulus(input logic [31:0] lk_pc, input logic uv, input logic [31:0] up,
                                 input logic uj, input logic ut, input logic [31:0] utg,
                                 input logic mp, input logic cl);
        @(negedge clk);
        pc_if       = lk_pc;
        upd_valid   = uv;
        upd_pc      = up;
        upd_is_jump = uj;
        upd_taken   = ut;
        upd_target  = utg;
        mispred     = mp;
        tbl_clear   = cl;
        #1;
        checkLookup("lookup");
        @(posedge clk);
        modelUpdate(uv, up, uj, ut, utg, mp, cl);
        #1;
        checkOutput("ctrl_cnt",    ctrl_cnt,    m_ctrl);
        checkOutput("mispred_cnt", mispred_cnt, m_misp);
        upd_valid = 1'b0;
        mispred   = 1'b0;
        tbl_clear = 1'b0;
    endtask

    // Idle lookup with a fixed expected next PC, also cross-checked against the model.
    task automatic expectNext(input logic [31:0] pc, input logic [31:0] exp_npc);
        @(negedge clk);
        pc_if = pc;
        #1;
        checkOutput("fixed_next_pc", next_pc, exp_npc);
        checkLookup("idle");
    endtask

    // Asynchronous reset in mid-cycle, checked while asserted, released on a falling edge.
    task automatic doReset();
        #2;
        rst_n = 1'b0;
        modelReset();
        pc_if = 32'h100;
        #1;
        checkOutput("rst_hit",         {31'd0, hit}, 32'd0);
        checkOutput("rst_next_pc",     next_pc,      32'h104);
        checkOutput("rst_ctrl_cnt",    ctrl_cnt,     32'd0);
        checkOutput("rst_mispred_cnt", mispred_cnt,  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] randPc();
        return ($urandom_range(0, 7) * 64) + ($urandom_range(0, 15) * 4) + $urandom_range(0, 3);
    endfunction

    initial begin
        n_checks    = 0;
        n_passed    = 0;
        rst_n       = 1'b1;
        pc_if       = 32'h0;
        upd_valid   = 1'b0;
        upd_pc      = 32'h0;
        upd_is_jump = 1'b0;
        upd_taken   = 1'b0;
        upd_target  = 32'h0;
        mispred     = 1'b0;
        tbl_clear   = 1'b0;
        modelReset();
        doReset();

        $display("[TB] branch training");
        applyStimulus(32'h0, 1, 32'h40, 0, 1, 32'h80, 0, 0);
        expectNext(32'h40, 32'h80);
        applyStimulus(32'h40, 1, 32'h40, 0, 0, 32'h80, 1, 0);
        expectNext(32'h40, 32'h44);
        applyStimulus(32'h40, 1, 32'h40, 0, 0, 32'h80, 0, 0);
        expectNext(32'h40, 32'h44);
        applyStimulus(32'h40, 1, 32'h40, 0, 1, 32'h80, 0, 0);
        expectNext(32'h40, 32'h44);
        for (int i = 0; i < 3; i++) applyStimulus(32'h40, 1, 32'h40, 0, 1, 32'h80, 0, 0);
        applyStimulus(32'h40, 1, 32'h40, 0, 0, 32'h80, 0, 0);
        expectNext(32'h40, 32'h80);

        $display("[TB] alias and JALR");
        applyStimulus(32'h40, 1, 32'h40, 1, 0, 32'h300, 0, 0);
        expectNext(32'h40, 32'h300);
        applyStimulus(32'h440, 1, 32'h440, 0, 1, 32'h500, 0, 0);
        expectNext(32'h40, 32'h44);
        expectNext(32'h440, 32'h500);
        applyStimulus(32'h440, 1, 32'h440, 1, 0, 32'h600, 0, 0);
        expectNext(32'h440, 32'h600);

        $display("[TB] same-cycle collisions");
        applyStimulus(32'h440, 1, 32'h440, 1, 1, 32'h700, 0, 0);
        expectNext(32'h440, 32'h700);
        applyStimulus(32'h80, 1, 32'h80, 1, 1, 32'h900, 1, 1);
        expectNext(32'h80, 32'h84);
        expectNext(32'h440, 32'h444);
        expectNext(32'hFFFF_FFFC, 32'h0);

        $display("[TB] not-taken miss");
        applyStimulus(32'h200, 1, 32'h200, 0, 0, 32'h280, 0, 0);
        expectNext(32'h200, 32'h204);

        $display("[TB] event counters");
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(32'h1000, 1, 32'h1000 + 32'(i * 4), 0, 1'(i % 2), 32'h2000,
                          1'((i % 3 == 0) && (i < 9)), 0);
        end
        applyStimulus(32'h1000, 0, 32'h1000, 0, 0, 32'h0, 1, 0);
        checkOutput("ctrl_cnt_10",   ctrl_cnt,    32'd10);
        checkOutput("mispred_cnt_3", mispred_cnt, 32'd3);

        @(negedge clk);
        force dut.ctrl_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.ctrl_cnt_q;
        m_ctrl = 32'hFFFF_FFFF;
        applyStimulus(32'h1000, 1, 32'h1000, 0, 0, 32'h0, 0, 0);
        checkOutput("ctrl_cnt_wrap", ctrl_cnt, 32'd0);

        $display("[TB] randomized training");
        for (int i = 0; i < 400; i++) begin
            logic uv, uj, ut, mp, cl;
            logic [31:0] lk;
            uv = 1'($urandom_range(0, 3) != 0);
            uj = 1'($urandom_range(0, 4) == 0);
            ut = 1'($urandom_range(0, 1));
            mp = 1'($urandom_range(0, 5) == 0);
            cl = 1'($urandom_range(0, 59) == 0);
            lk = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : randPc();
            applyStimulus(lk, uv, randPc(), uj, ut, $urandom() & 32'hFFFF_FFFC, mp, cl);
        end

        $display("[TB] reset with live entries");
        doReset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(randPc(), 1'($urandom_range(0, 1)), randPc(), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), 0);
        end

        $display("[TB] %0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/br_btb.md
# br_btb

Direct-mapped branch target buffer with 2-bit saturating direction counters for the IF stage of the pipelined RV32I core. It replaces the static always-taken policy: each cycle it looks up the fetch PC and supplies a predicted next PC, and it is trained by the EX-stage branch resolution results. It also keeps control-flow and misprediction event counters for performance debug.

## Interface
Parameters:
- ENTRIES, 16, number of table entries; power of two, 4..256.
- INDEX_W, $clog2(ENTRIES), index width; derived, not overridden.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_pc_if  in  32  fetch PC being looked up this cycle.
- o_hit  out  1  valid entry whose tag matches i_pc_if.
- o_pred_taken  out  1  predicted taken.
- o_next_pc  out  32  predicted next fetch PC.
- i_upd_valid  in  1  one resolved control-flow instruction in EX this cycle.
- i_upd_pc  in  32  PC of the resolved instruction.
- i_upd_is_jump  in  1  JAL/JALR when 1; conditional branch when 0.
- i_upd_taken  in  1  actual outcome; ignored and treated as 1 when i_upd_is_jump=1.
- i_upd_target  in  32  actual taken target (ALU result).
- i_mispred  in  1  EX detected a misprediction for the i_upd_valid instruction.
- i_tbl_clear  in  1  synchronous invalidate-all, e.g. after self-modifying code.
- o_ctrl_cnt  out  32  resolved control-flow instructions.
- o_mispred_cnt  out  32  mispredictions.

## Operation
- Fields: idx = pc[INDEX_W+1:2]; tag = pc[31:INDEX_W+2]. pc[1:0] is ignored.
- Each entry holds:
  - valid (1 bit)
  - tag
  - target (32 bits)
  - is_jump (1 bit)
  - ctr (2 bits: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
- Lookup is purely combinational from i_pc_if and the current table contents:
  - o_hit = valid[idx] & (tag[idx] == tag(i_pc_if)).
  - o_pred_taken = o_hit & (is_jump[idx] | ctr[idx][1]).
  - o_next_pc = o_pred_taken ? target[idx] : i_pc_if + 4, computed mod 2^32, so 0xFFFFFFFC wraps to 0x00000000.
- Update on a clock edge with i_upd_valid=1 and i_tbl_clear=0. Let taken_eff = i_upd_is_jump | i_upd_taken.
  - **Hit, conditional branch:** ctr saturating-increments if taken, else saturating-decrements. At 11 it stays 11 when taken; at 00 it stays 00 when not taken. target is written with i_upd_target only when taken.
  - **Hit, jump:** target is written with i_upd_target, ctr=11, is_jump=1. JALR targets are retrained on every execution.
  - **Miss (invalid entry, or tag mismatch) and taken_eff=1:** allocate or replace the entry with valid=1, new tag, target=i_upd_target, is_jump=i_upd_is_jump, and ctr=11 for a jump or 10 for a branch.
  - **Miss and taken_eff=0:** no table write.
- i_tbl_clear=1: all valid bits cleared at the edge. It wins over a same-cycle update, so no entry is allocated that cycle. Event counters still count that cycle.
- Counters, on each edge:
  - o_ctrl_cnt += i_upd_valid.
  - o_mispred_cnt += i_upd_valid & i_mispred. i_mispred without i_upd_valid is ignored.
  - Both wrap modulo 2^32.
- Reset (async assert): all valid=0, ctr=01, target/tag=0, both counters=0. Consequences: o_hit=0, o_pred_taken=0, o_next_pc=i_pc_if+4. Reset mid-operation discards all training immediately; no pending update completes.

## Timing
- Lookup latency 0 cycles: outputs follow i_pc_if and the table within the same cycle.
- Update latency 1 cycle: an update sampled at edge N is visible to lookups after edge N.
- Same-index read/write in one cycle: the lookup returns the pre-update contents. There is no write-to-read bypass.
- One update per cycle maximum. There are no handshakes; the EX stage must assert i_upd_valid for exactly one cycle per resolved instruction. The pipeline must not assert it for flushed or bubble slots.
- Counters update on the same edge as the table.
- Reset deassertion is assumed synchronised upstream. The first lookup after reset sees an empty table.

## Test plan
- **Reset:** assert i_rst_n=0 mid-run with live entries, then release. Required: o_hit=0, o_next_pc=i_pc_if+4 for PC 0x100 (→0x104), o_ctrl_cnt=o_mispred_cnt=0.
- **Branch training:** update PC 0x40 branch taken, target 0x80. Next cycle, lookup 0x40 gives hit=1, taken=1, next_pc=0x80. Then not-taken twice: ctr goes 10→01→00 and the lookup gives next_pc=0x44. Then taken ×4: ctr saturates at 11. One not-taken afterwards still predicts taken.
- **Not-taken miss:** update PC 0x200 branch not-taken on an empty table. Required: no allocation, lookup 0x200 gives hit=0.
- **Alias and JALR:** with ENTRIES=16, allocate a jump at 0x40 with target 0x300. Then update taken branch 0x440 (same idx, different tag) with target 0x500. Required: 0x40 now misses; 0x440 hits with next_pc=0x500. Re-execute JALR 0x440 with target 0x600: next_pc becomes 0x600.
- **Same-cycle collisions:**
  - Update 0x40 and lookup 0x40 in one cycle: the lookup shows the old value.
  - i_tbl_clear together with an update: the table ends empty.
  - Wrap: lookup 0xFFFFFFFC on a miss gives next_pc=0x00000000.
- **Counters:** 10 updates, 3 of them with i_mispred=1, plus one i_mispred pulse without i_upd_valid. Required: o_ctrl_cnt=10, o_mispred_cnt=3. Force o_ctrl_cnt to 0xFFFFFFFF, then one update: it reads 0.
